// File: rtl/i2c_regmap.sv
// Register map between the SCL-domain I2C slave and the system clock domain:
// synchronised write commit, stability-filtered read address, sticky events.
module i2c_regmap #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned NUM_STATUS  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              i2c_addr,
  input  logic [7:0]              i2c_wdata,
  input  logic                    i2c_wr_pulse,
  input  logic                    i2c_active,
  output logic [7:0]              i2c_rdata,
  output logic [8*NUM_REGS-1:0]   ctrl_regs,
  input  logic [(NUM_STATUS > 0 ? 8*NUM_STATUS : 8)-1:0] status_in,
  input  logic [7:0]              event_in,
  output logic                    wr_strobe,
  output logic [7:0]              wr_addr,
  output logic [7:0]              wr_data,
  output logic                    busy
);

  localparam logic [7:0] REGS_END  = 8'(NUM_REGS);
  localparam logic [7:0] EVT_ADDR  = 8'h7E;
  localparam logic [7:0] ID_ADDR   = 8'h7F;
  localparam int unsigned STAT_BASE = 32'h80;

  logic [SYNC_STAGES-1:0] wr_sync;
  logic                   wr_hist;
  logic [SYNC_STAGES-1:0] act_sync;
  logic [7:0]             evt_q;
  logic [7:0]             a1;
  logic [7:0]             a2;
  logic [7:0]             rd_addr;

  logic       commit_c;
  logic       is_ctrl_c;
  logic [7:0] evt_clr_c;
  logic [7:0] rd_mux_c;

  assign commit_c  = wr_sync[SYNC_STAGES-1] & ~wr_hist;
  assign is_ctrl_c = (i2c_addr < REGS_END);
  assign evt_clr_c = (commit_c && (i2c_addr == EVT_ADDR)) ? i2c_wdata : 8'h00;
  assign busy      = act_sync[SYNC_STAGES-1];

  // Chain and history reset high so a pulse held across reset never looks like a rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sync  <= '1;
      wr_hist  <= 1'b1;
      act_sync <= '0;
    end else begin
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0], i2c_wr_pulse};
      wr_hist  <= wr_sync[SYNC_STAGES-1];
      act_sync <= {act_sync[SYNC_STAGES-2:0], i2c_active};
    end
  end

  // Commit: address and data are quasi-static around the pulse, so sampled directly
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_regs <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
    end else begin
      wr_strobe <= commit_c & is_ctrl_c;
      if (commit_c && is_ctrl_c) begin
        wr_addr <= i2c_addr;
        wr_data <= i2c_wdata;
      end
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (commit_c && (i2c_addr == 8'(i))) begin
          ctrl_regs[8*i +: 8] <= i2c_wdata;
        end
      end
    end
  end

  // Sticky events: a set in the same cycle as a write-1 clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q <= 8'h00;
    end else begin
      evt_q <= (evt_q & ~evt_clr_c) | event_in;
    end
  end

  // Read address only advances once two consecutive samples agree
  always_ff @(posedge clk) begin
    if (rst) begin
      a1        <= 8'h00;
      a2        <= 8'h00;
      rd_addr   <= 8'h00;
      i2c_rdata <= 8'h00;
    end else begin
      a1        <= i2c_addr;
      a2        <= a1;
      if (a1 == a2) begin
        rd_addr <= a2;
      end
      i2c_rdata <= rd_mux_c;
    end
  end

  always_comb begin
    rd_mux_c = 8'h00;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 8'(i)) begin
        rd_mux_c = ctrl_regs[8*i +: 8];
      end
    end
    if (rd_addr == EVT_ADDR) begin
      rd_mux_c = evt_q;
    end
    if (rd_addr == ID_ADDR) begin
      rd_mux_c = ID_VALUE;
    end
    for (int unsigned i = 0; i < NUM_STATUS; i++) begin
      if (rd_addr == 8'(STAT_BASE + i)) begin
        rd_mux_c = status_in[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_i2c_regmap.sv
// Self-checking bench for i2c_regmap: vector table, hand-timed corner cases
// and random traffic against an address-map model.
module tb_i2c_regmap;

  localparam int unsigned NUM_REGS    = 16;
  localparam int unsigned NUM_STATUS  = 4;
  localparam int unsigned SYNC_STAGES = 2;

  logic                  clk;
  logic                  rst;
  logic [7:0]            i2c_addr;
  logic [7:0]            i2c_wdata;
  logic                  i2c_wr_pulse;
  logic                  i2c_active;
  logic [7:0]            i2c_rdata;
  logic [8*NUM_REGS-1:0] ctrl_regs;
  logic [31:0]           status_in;
  logic [7:0]            event_in;
  logic                  wr_strobe;
  logic [7:0]            wr_addr;
  logic [7:0]            wr_data;
  logic                  busy;

  i2c_regmap #(
    .NUM_REGS(NUM_REGS), .NUM_STATUS(NUM_STATUS),
    .SYNC_STAGES(SYNC_STAGES), .ID_VALUE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_wr_pulse(i2c_wr_pulse), .i2c_active(i2c_active), .i2c_rdata(i2c_rdata),
    .ctrl_regs(ctrl_regs), .status_in(status_in), .event_in(event_in),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;

  always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  // Reference model state
  logic [7:0] ctrl_m [NUM_REGS];
  logic [7:0] evt_m;
  logic [7:0] wr_addr_m;
  logic [7:0] wr_data_m;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         len;
    int         strobes;
    logic [7:0] rdback;
  } vec_t;

  vec_t vecs [11];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [8*NUM_REGS-1:0] act,
                           input logic [8*NUM_REGS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [7:0] a);
    int ai = int'(a);
    if (ai < int'(NUM_REGS)) return ctrl_m[ai];
    if (ai == 126) return evt_m;
    if (ai == 127) return 8'hA5;
    if (ai >= 128 && ai < 128 + int'(NUM_STATUS)) return status_in[8*(ai-128) +: 8];
    return 8'h00;
  endfunction

  // Applies a write to the model; returns the number of strobes it should cause
  function automatic int model_write(input logic [7:0] a, input logic [7:0] d);
    int ai = int'(a);
    if (ai < int'(NUM_REGS)) begin
      ctrl_m[ai] = d;
      wr_addr_m  = a;
      wr_data_m  = d;
      return 1;
    end
    if (ai == 126) evt_m = evt_m & ~d;
    return 0;
  endfunction

  function automatic logic [8*NUM_REGS-1:0] exp_ctrl();
    logic [8*NUM_REGS-1:0] v = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) v[8*i +: 8] = ctrl_m[i];
    return v;
  endfunction

  task automatic write_txn(input logic [7:0] a, input logic [7:0] d, input int len,
                           output int strobes);
    int s0;
    i2c_addr  = a;
    i2c_wdata = d;
    tick(1);
    s0 = strobe_cnt;
    i2c_wr_pulse = 1'b1;
    tick(len);
    i2c_wr_pulse = 1'b0;
    tick(4);
    strobes = strobe_cnt - s0;
  endtask

  task automatic read_val(input logic [7:0] a, output logic [7:0] v);
    i2c_addr = a;
    tick(4);
    v = i2c_rdata;
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(0, NUM_REGS - 1));
      1:       return 8'h7E;
      2:       return 8'($urandom_range(0, 255));
      default: return 8'(8'h80 + 8'($urandom_range(0, NUM_STATUS)));
    endcase
  endfunction

  initial begin
    int s, s0;
    logic [7:0] v, a, d;

    for (int i = 0; i < int'(NUM_REGS); i++) ctrl_m[i] = 8'h00;
    evt_m = 8'h00; wr_addr_m = 8'h00; wr_data_m = 8'h00;

    vecs[0]  = '{8'h05, 8'h11, 6,  1, 8'h11};
    vecs[1]  = '{8'h06, 8'h22, 3,  1, 8'h22};
    vecs[2]  = '{8'h07, 8'h33, 1,  1, 8'h33};
    vecs[3]  = '{8'h40, 8'h99, 5,  0, 8'h00};
    vecs[4]  = '{8'h7F, 8'h12, 4,  0, 8'hA5};
    vecs[5]  = '{8'h81, 8'h77, 4,  0, 8'h3C};
    vecs[6]  = '{8'h0F, 8'hF0, 9,  1, 8'hF0};
    vecs[7]  = '{8'h10, 8'hAB, 2,  0, 8'h00};
    vecs[8]  = '{8'h84, 8'hCD, 2,  0, 8'h00};
    vecs[9]  = '{8'h80, 8'h01, 7,  0, 8'h11};
    vecs[10] = '{8'h00, 8'h6E, 20, 1, 8'h6E};

    rst = 1'b1; i2c_wr_pulse = 1'b1; i2c_active = 1'b0;
    i2c_addr = 8'h00; i2c_wdata = 8'h00; event_in = 8'h00;
    status_in = 32'hDDEE3C11;

    // Reset with the write pulse held across release
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick(5);
    i2c_wr_pulse = 1'b0;
    tick(5);
    check_int("reset_strobes", strobe_cnt, 0);
    check8("reset_wr_strobe", {7'd0, wr_strobe}, 8'h00);
    check_vec("reset_ctrl", ctrl_regs, '0);
    check8("reset_wr_addr", wr_addr, 8'h00);
    check8("reset_wr_data", wr_data, 8'h00);
    check8("reset_busy", {7'd0, busy}, 8'h00);
    check8("reset_rdata", i2c_rdata, 8'h00);

    // Single write with exact commit timing
    i2c_addr = 8'h03; i2c_wdata = 8'h5C;
    tick(1);
    s0 = strobe_cnt;
    i2c_wr_pulse = 1'b1;
    tick(1);
    check8("single_k0_strobe", {7'd0, wr_strobe}, 8'h00);
    tick(1);
    check8("single_k1_strobe", {7'd0, wr_strobe}, 8'h00);
    check8("single_k1_byte", ctrl_regs[8*3 +: 8], 8'h00);
    tick(1);
    check8("single_k2_strobe", {7'd0, wr_strobe}, 8'h01);
    check8("single_k2_byte", ctrl_regs[8*3 +: 8], 8'h5C);
    check8("single_wr_addr", wr_addr, 8'h03);
    check8("single_wr_data", wr_data, 8'h5C);
    tick(1);
    check8("single_k3_strobe", {7'd0, wr_strobe}, 8'h00);
    tick(36);
    i2c_wr_pulse = 1'b0;
    tick(4);
    check_int("single_strobe_count", strobe_cnt - s0, 1);
    s = model_write(8'h03, 8'h5C);
    read_val(8'h03, v);
    check8("single_readback", v, 8'h5C);

    // Table of writes with readback
    for (int i = 0; i < 11; i++) begin
      write_txn(vecs[i].addr, vecs[i].data, vecs[i].len, s);
      check_int($sformatf("vec%0d_strobes", i), s, vecs[i].strobes);
      s = model_write(vecs[i].addr, vecs[i].data);
      read_val(vecs[i].addr, v);
      check8($sformatf("vec%0d_read", i), v, vecs[i].rdback);
    end
    check_vec("table_ctrl", ctrl_regs, exp_ctrl());
    check8("table_wr_addr", wr_addr, 8'h00);
    check8("table_wr_data", wr_data, 8'h6E);

    // Address toggling every clk must not disturb the read
    read_val(8'h05, v);
    check8("stable_pre", v, 8'h11);
    for (int i = 0; i < 20; i++) begin
      i2c_addr = (i % 2 == 0) ? 8'h7F : 8'h81;
      tick(1);
      check8($sformatf("toggle%0d", i), i2c_rdata, 8'h11);
    end
    read_val(8'h7F, v);
    check8("toggle_settle_id", v, 8'hA5);

    // Sticky events and write-1-to-clear
    event_in = 8'h81;
    tick(1);
    event_in = 8'h00;
    evt_m = evt_m | 8'h81;
    read_val(8'h7E, v);
    check8("evt_set", v, 8'h81);
    write_txn(8'h7E, 8'h01, 5, s);
    check_int("evt_clr_strobes", s, 0);
    s = model_write(8'h7E, 8'h01);
    read_val(8'h7E, v);
    check8("evt_clr", v, 8'h80);

    // Set in the commit cycle wins over the clear
    i2c_addr = 8'h7E; i2c_wdata = 8'h01;
    tick(1);
    i2c_wr_pulse = 1'b1;
    tick(2);
    event_in = 8'h01;
    tick(1);
    event_in = 8'h00;
    tick(3);
    i2c_wr_pulse = 1'b0;
    tick(4);
    read_val(8'h7E, v);
    check8("evt_set_wins", v, 8'h81);

    // Set one cycle before the commit is cleared by it
    i2c_addr = 8'h7E; i2c_wdata = 8'h01;
    tick(1);
    i2c_wr_pulse = 1'b1;
    tick(1);
    event_in = 8'h01;
    tick(1);
    event_in = 8'h00;
    tick(4);
    i2c_wr_pulse = 1'b0;
    tick(4);
    read_val(8'h7E, v);
    check8("evt_early_set_cleared", v, 8'h80);
    evt_m = 8'h80;

    // busy follows i2c_active after two edges
    i2c_active = 1'b1;
    tick(1);
    check8("busy_rise_1", {7'd0, busy}, 8'h00);
    tick(1);
    check8("busy_rise_2", {7'd0, busy}, 8'h01);
    i2c_active = 1'b0;
    tick(1);
    check8("busy_fall_1", {7'd0, busy}, 8'h01);
    tick(1);
    check8("busy_fall_2", {7'd0, busy}, 8'h00);

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          a = rand_addr();
          d = 8'($urandom);
          write_txn(a, d, int'($urandom_range(1, 12)), s);
          check_int($sformatf("rnd%0d_strobes", i), s, model_write(a, d));
          check8($sformatf("rnd%0d_wr_addr", i), wr_addr, wr_addr_m);
          check8($sformatf("rnd%0d_wr_data", i), wr_data, wr_data_m);
        end
        2: begin
          d = 8'($urandom);
          event_in = d;
          tick(1);
          event_in = 8'h00;
          evt_m = evt_m | d;
        end
        default: begin
          status_in = $urandom;
          a = rand_addr();
          read_val(a, v);
          check8($sformatf("rnd%0d_read_%02h", i, a), v, exp_read(a));
        end
      endcase
    end
    check_vec("final_ctrl", ctrl_regs, exp_ctrl());
    read_val(8'h7E, v);
    check8("final_evt", v, evt_m);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
